// File: rtl/uart_mem_loader_if.sv
// ---------------------------------------------------------------------------
// uart_mem_loader_if
//   Memory write bus driven by the UART memory loader.
//
//   Handshake: this bus has a valid strobe only and no ready. `we` is the
//   valid; it is high for exactly one clk cycle per word, and address and
//   data_out are stable while it is high. The memory side must accept the
//   write in that cycle. There is no back-pressure.
//
//   Signals
//     we        1        one-cycle write strobe
//     address   ADDR_W   word address, valid while we=1
//     data_out  DATA_W   packed word, valid while we=1 (holds afterwards)
//
//   Modports
//     master  loader side (drives the bus)
//     slave   memory side (observes the bus)
// ---------------------------------------------------------------------------
interface uart_mem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_out;

    modport master (output we, output address, output data_out);
    modport slave  (input  we, input  address, input  data_out);
endinterface

// File: rtl/uart_mem_loader.sv
// ---------------------------------------------------------------------------
// uart_mem_loader
//   UART receiver that packs WORD_BYTES characters into one little-endian
//   word and writes it to memory through a one-cycle strobe. It raises `done`
//   after NUM_WORDS words have been written. It flags framing and parity
//   errors on a sticky `err` output.
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   synchronous reset, active low (0 = reset)
//     en         in   receive enable; dropping it aborts the current character
//     rx         in   serial line, idle high, asynchronous to clk
//     bus        mst  memory write bus (we / address / data_out)
//     done       out  NUM_WORDS words written; sticky until reset
//     err        out  framing or parity error seen; sticky until reset
//     busy       out  receiver FSM is not idle
//     state_dbg  out  current FSM state encoding, for debug and checkers
// ---------------------------------------------------------------------------
module uart_mem_loader #(
    parameter int                CLKS_PER_BIT = 16,
    parameter int                DATA_BITS    = 8,
    parameter int                PARITY       = 0,
    parameter int                WORD_BYTES   = 4,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                NUM_WORDS    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      rx,
    uart_mem_loader_if.master         bus,
    output logic                      done,
    output logic                      err,
    output logic                      busy,
    output logic [2:0]                state_dbg
);

    localparam int WORD_W = DATA_BITS * WORD_BYTES;
    localparam int TW     = $clog2(CLKS_PER_BIT);
    localparam int WC_W   = $clog2(NUM_WORDS + 1);

    // Timer terminal counts: half a bit to reach the middle of the start bit,
    // then a full bit between successive mid-bit samples.
    localparam logic [TW-1:0]   HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]   BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      DBIT_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      BYTE_LAST = 4'(WORD_BYTES - 1);
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state;
    logic                rx_meta;
    logic                rx_sync;
    logic                rx_prev;
    logic [TW-1:0]       timer;
    logic [3:0]          bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                par_bad;
    logic [3:0]          byte_cnt;
    logic [WORD_W-1:0]   word_buf;
    logic [WORD_W-1:0]   word_next;
    logic [WC_W-1:0]     word_cnt;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [WORD_W-1:0]   data_r;
    logic                done_r;
    logic                err_r;
    logic                par_mismatch;

    // The partial word with the character just received dropped into its
    // slot. The first character of a word lands in the lowest bits.
    always_comb begin
        word_next = word_buf;
        word_next[int'(byte_cnt) * DATA_BITS +: DATA_BITS] = shreg;
    end

    // Even parity: data XOR parity bit must be 0. Odd parity: it must be 1.
    always_comb begin
        par_mismatch = (^shreg) ^ rx_sync;
        if (PARITY == 2) begin
            par_mismatch = ~par_mismatch;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            timer    <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            byte_cnt <= '0;
            word_buf <= '0;
            word_cnt <= '0;
            we_r     <= 1'b0;
            addr_r   <= BASE_ADDR;
            data_r   <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;

            // Retire the write one cycle after the strobe. The FSM is always
            // idle in this cycle because the stop sample returns it to IDLE.
            if (we_r) begin
                we_r     <= 1'b0;
                addr_r   <= addr_r + ADDR_W'(WORD_BYTES);
                byte_cnt <= '0;
                word_cnt <= word_cnt + 1'b1;
                if (word_cnt == WORD_LAST) begin
                    done_r <= 1'b1;
                end
            end

            if (state != S_IDLE && !en) begin
                // Abort: the partial character is dropped. The partial word
                // and the address are kept.
                state <= S_IDLE;
                timer <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (en && !done_r && rx_prev && !rx_sync) begin
                            state <= S_START;
                            timer <= '0;
                        end
                    end

                    S_START: begin
                        if (timer == HALF_LAST) begin
                            timer   <= '0;
                            bit_idx <= '0;
                            par_bad <= 1'b0;
                            // Line already high again at mid start bit: glitch.
                            state   <= rx_sync ? S_IDLE : S_DATA;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end

                    S_DATA: begin
                        if (timer == BIT_LAST) begin
                            timer <= '0;
                            shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
                            if (bit_idx == DBIT_LAST) begin
                                state <= (PARITY != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end

                    S_PARITY: begin
                        if (timer == BIT_LAST) begin
                            timer   <= '0;
                            par_bad <= par_mismatch;
                            state   <= S_STOP;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end

                    S_STOP: begin
                        if (timer == BIT_LAST) begin
                            timer <= '0;
                            state <= S_IDLE;
                            if (!rx_sync || par_bad) begin
                                err_r <= 1'b1;
                            end else begin
                                word_buf <= word_next;
                                if (byte_cnt == BYTE_LAST) begin
                                    we_r   <= 1'b1;
                                    data_r <= word_next;
                                end else begin
                                    byte_cnt <= byte_cnt + 1'b1;
                                end
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.we       = we_r;
    assign bus.address  = addr_r;
    assign bus.data_out = data_r;
    assign done         = done_r;
    assign err          = err_r;
    assign busy         = (state != S_IDLE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_uart_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_mem_loader
//   Bench for uart_mem_loader with CLKS_PER_BIT=4, DATA_BITS=8, WORD_BYTES=4,
//   NUM_WORDS=2. One instance has no parity; a second instance uses even
//   parity. Expected words come from a byte-list model of the loader.
// ---------------------------------------------------------------------------
module tb_uart_mem_loader;
    localparam int CPB = 4;
    localparam int WB  = 4;
    localparam int NW  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic en    = 1'b0;
    logic rx    = 1'b1;
    logic rx_p  = 1'b1;
    logic done, err, busy, done_p, err_p, busy_p;
    logic [2:0] st, st_p;

    uart_mem_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    uart_mem_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus_p ();

    uart_mem_loader #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .WORD_BYTES(WB),
        .ADDR_W(AW), .BASE_ADDR('0), .NUM_WORDS(NW)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .rx(rx), .bus(bus.master),
        .done(done), .err(err), .busy(busy), .state_dbg(st)
    );

    uart_mem_loader #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .WORD_BYTES(WB),
        .ADDR_W(AW), .BASE_ADDR('0), .NUM_WORDS(NW)
    ) dut_par (
        .clk(clk), .reset(reset), .en(en), .rx(rx_p), .bus(bus_p.master),
        .done(done_p), .err(err_p), .busy(busy_p), .state_dbg(st_p)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- bus monitor ----------------
    logic [31:0] obs_d[$];
    logic [31:0] obs_a[$];
    logic [31:0] obs_pd[$];
    int   we_double = 0;
    bit   busy_seen = 0;
    logic we_prev   = 1'b0;
    logic done_prev = 1'b0;
    int   cyc = 0;
    int   we_cyc = -10;
    int   done_cyc = -20;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.we === 1'b1) begin
            obs_d.push_back(bus.data_out);
            obs_a.push_back(bus.address);
            we_cyc = cyc;
            if (we_prev === 1'b1) we_double = we_double + 1;
        end
        if (done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
        we_prev   = bus.we;
        done_prev = done;
        if (busy === 1'b1) busy_seen = 1;
        if (bus_p.we === 1'b1) obs_pd.push_back(bus_p.data_out);
    end

    // ---------------- reference model ----------------
    // Accepted bytes are collected in order; every WB of them make one word
    // at the current address. Nothing is accepted once NW words exist.
    logic [7:0]  m_bytes[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_a[$];
    logic [31:0] m_addr;
    int          m_words;
    bit          m_done;

    function automatic void model_reset();
        m_bytes.delete();
        exp_q.delete();
        exp_a.delete();
        m_addr  = 32'd0;
        m_words = 0;
        m_done  = 0;
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        logic [31:0] w;
        w = 32'd0;
        if (m_done) return;
        m_bytes.push_back(b);
        if (m_bytes.size() == WB) begin
            for (int i = 0; i < WB; i++) w = w | (32'(m_bytes[i]) << (8 * i));
            exp_q.push_back(w);
            exp_a.push_back(m_addr);
            m_addr  = m_addr + WB;
            m_words = m_words + 1;
            if (m_words == NW) m_done = 1;
            m_bytes.delete();
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_bit(input bit sel, input logic v);
        @(negedge clk);
        if (sel) rx_p = v;
        else     rx   = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop_v,
                              input bit has_par, input logic par_v);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (has_par) drive_bit(sel, par_v);
        drive_bit(sel, stop_v);
        drive_bit(sel, 1'b1);
        drive_bit(sel, 1'b1);
    endtask

    // Start bit plus the first nbits data bits, then return mid-frame.
    task automatic send_partial(input logic [7:0] d, input int nbits);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(1'b0, d[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        rx_p  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        obs_d.delete();
        obs_a.delete();
        obs_pd.delete();
        we_double = 0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.we); end
        checks++; if (bus.data_out !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.data_out); end
        checks++; if (bus.address !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.address); end
        checks++; if ({done, err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got done/err/busy=%b expected 000", {done, err, busy}); end
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_word_write();
        logic [7:0] bytes_in[4];
        bytes_in = '{8'h78, 8'h56, 8'h34, 8'h12};
        for (int i = 0; i < 4; i++) begin
            send_frame(1'b0, bytes_in[i], 1'b1, 1'b0, 1'b0);
            model_accept(bytes_in[i]);
        end
        checks++; if (obs_d.size() != 1) begin errors++; $display("FAIL word_count: got %0d expected 1", obs_d.size()); end
        checks++; if (obs_d[0] !== exp_q[0]) begin errors++; $display("FAIL word_data: got %h expected %h", obs_d[0], exp_q[0]); end
        checks++; if (obs_a[0] !== exp_a[0]) begin errors++; $display("FAIL word_addr: got %h expected %h", obs_a[0], exp_a[0]); end
        checks++; if (bus.address !== m_addr) begin errors++; $display("FAIL addr_after: got %h expected %h", bus.address, m_addr); end
        checks++; if (we_double != 0) begin errors++; $display("FAIL we_width: got %0d multi-cycle strobes expected 0", we_double); end
    endtask

    task automatic test_done();
        for (int i = 0; i < 4; i++) begin
            send_frame(1'b0, 8'hCC, 1'b1, 1'b0, 1'b0);
            model_accept(8'hCC);
        end
        checks++; if (obs_d.size() != 2) begin errors++; $display("FAIL done_count: got %0d expected 2", obs_d.size()); end
        checks++; if (obs_d[1] !== exp_q[1]) begin errors++; $display("FAIL done_data: got %h expected %h", obs_d[1], exp_q[1]); end
        checks++; if (obs_a[1] !== exp_a[1]) begin errors++; $display("FAIL done_addr: got %h expected %h", obs_a[1], exp_a[1]); end
        checks++; if (done !== m_done) begin errors++; $display("FAIL done_flag: got %b expected %b", done, m_done); end
        checks++; if (done_cyc != we_cyc + 1) begin errors++; $display("FAIL done_timing: got cycle %0d expected %0d", done_cyc, we_cyc + 1); end
        busy_seen = 0;
        send_frame(1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
        model_accept(8'h11);
        checks++; if (obs_d.size() != exp_q.size()) begin errors++; $display("FAIL after_done_we: got %0d writes expected %0d", obs_d.size(), exp_q.size()); end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL after_done_busy: got busy=1 expected 0"); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b expected 1", done); end
    endtask

    task automatic test_glitch();
        do_reset();
        busy_seen = 0;
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++; if (busy_seen != 1) begin errors++; $display("FAIL glitch_busy_pulse: got %0d expected 1", busy_seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy=%b expected 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL glitch_err: got %b expected 0", err); end
    endtask

    // Runs straight after the glitch without a reset, so the written word also
    // shows that neither the glitch nor the bad frame advanced the byte count.
    task automatic test_framing();
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL framing_err: got %b expected 1", err); end
        for (int i = 0; i < 4; i++) begin
            send_frame(1'b0, 8'hAA, 1'b1, 1'b0, 1'b0);
            model_accept(8'hAA);
        end
        checks++; if (obs_d.size() != 1) begin errors++; $display("FAIL framing_count: got %0d expected 1", obs_d.size()); end
        checks++; if (obs_d[0] !== exp_q[0]) begin errors++; $display("FAIL framing_data: got %h expected %h", obs_d[0], exp_q[0]); end
        checks++; if (obs_a[0] !== exp_a[0]) begin errors++; $display("FAIL framing_addr: got %h expected %h", obs_a[0], exp_a[0]); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    endtask

    task automatic test_parity();
        logic [7:0] b;
        do_reset();
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        checks++; if (err_p !== 1'b1) begin errors++; $display("FAIL parity_err: got %b expected 1", err_p); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL parity_other_err: got %b expected 0", err); end
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b0);
        model_accept(8'h03);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(1'b1, b, 1'b1, 1'b1, ^b);
            model_accept(b);
        end
        checks++; if (obs_pd.size() != 1) begin errors++; $display("FAIL parity_count: got %0d expected 1", obs_pd.size()); end
        checks++; if (obs_pd[0] !== exp_q[0]) begin errors++; $display("FAIL parity_data: got %h expected %h", obs_pd[0], exp_q[0]); end
    endtask

    task automatic test_en_drop();
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(1'b0, b, 1'b1, 1'b0, 1'b0);
            model_accept(b);
        end
        send_partial(8'h00, 3);
        @(negedge clk);
        en = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_drop_idle: got busy=%b expected 0", busy); end
        repeat (10 * CPB) @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (obs_d.size() != 0) begin errors++; $display("FAIL en_drop_we: got %0d writes expected 0", obs_d.size()); end
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(1'b0, b, 1'b1, 1'b0, 1'b0);
            model_accept(b);
        end
        checks++; if (obs_d.size() != 1) begin errors++; $display("FAIL en_resume_count: got %0d expected 1", obs_d.size()); end
        checks++; if (obs_d[0] !== exp_q[0]) begin errors++; $display("FAIL en_resume_data: got %h expected %h", obs_d[0], exp_q[0]); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL en_drop_err: got %b expected 0", err); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255)) | 8'h01;
            send_frame(1'b0, b, 1'b1, 1'b0, 1'b0);
        end
        send_partial(8'h5A, 3);
        @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        checks++; if (bus.data_out !== 32'd0) begin errors++; $display("FAIL midreset_data: got %h expected 0", bus.data_out); end
        checks++; if (bus.address !== 32'd0) begin errors++; $display("FAIL midreset_addr: got %h expected 0", bus.address); end
        checks++; if ({bus.we, done, err, busy} !== 4'b0000) begin errors++; $display("FAIL midreset_flags: got we/done/err/busy=%b expected 0000", {bus.we, done, err, busy}); end
        reset = 1'b1;
        model_reset();
        obs_d.delete();
        obs_a.delete();
        repeat (4 * CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(1'b0, b, 1'b1, 1'b0, 1'b0);
            model_accept(b);
        end
        checks++; if (obs_d.size() != 1) begin errors++; $display("FAIL midreset_count: got %0d expected 1", obs_d.size()); end
        checks++; if (obs_d[0] !== exp_q[0]) begin errors++; $display("FAIL midreset_word: got %h expected %h", obs_d[0], exp_q[0]); end
        checks++; if (obs_a[0] !== exp_a[0]) begin errors++; $display("FAIL midreset_waddr: got %h expected %h", obs_a[0], exp_a[0]); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop_v;
        bit         any_bad;
        do_reset();
        any_bad = 0;
        for (int i = 0; i < 14; i++) begin
            b      = 8'($urandom_range(0, 255));
            stop_v = ($urandom_range(0, 3) != 0);
            send_frame(1'b0, b, stop_v, 1'b0, 1'b0);
            if (!m_done) begin
                if (stop_v) model_accept(b);
                else        any_bad = 1;
            end
        end
        checks++; if (obs_d.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", obs_d.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (obs_d[i] !== exp_q[i] || obs_a[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL rand_word%0d: got %h@%h expected %h@%h", i, obs_d[i], obs_a[i], exp_q[i], exp_a[i]);
            end
        end
        checks++; if (done !== m_done) begin errors++; $display("FAIL rand_done: got %b expected %b", done, m_done); end
        checks++; if (err !== any_bad) begin errors++; $display("FAIL rand_err: got %b expected %b", err, any_bad); end
        checks++; if (we_double != 0) begin errors++; $display("FAIL rand_we_width: got %0d expected 0", we_double); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_word_write();
        test_done();
        test_glitch();
        test_framing();
        test_parity();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
